vdp_sprite_meta_dma: RTL and testbench
======================================

Name: vdp_sprite_meta_dma

Overview:
- Vblank copy engine that streams sprite attribute words from VRAM into the sprite core's x/y/g metadata blocks.
- It is the writer side of the sprite metadata interface: it drives meta_address, meta_write_data, meta_block_select and meta_we.
- It is an initiator on a VRAM read port and arbitrates for that port through the request/ack handshake.
- Removes per-sprite CPU register writes. The host sets a base address and a sprite count, then pulses start.

Parameters:
- MAX_SPRITES, 256, number of sprite slots in the metadata blocks; sprite_count is clamped to this.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse that begins a transfer; ignored while busy
- abort  in  1  one-cycle pulse that terminates a transfer early
- base_address  in  14  VRAM word address of sprite 0's x word; sampled on accepted start
- sprite_count  in  9  number of sprites to copy; 0 = no-op; sampled on accepted start
- busy  out  1  high from the cycle after an accepted start until the transfer ends
- done  out  1  one-cycle pulse on normal completion
- vram_read_request  out  1  read request; held until acked
- vram_read_address  out  14  request address; stable while the request is pending
- vram_read_ack  in  1  request accepted this cycle
- vram_read_data  in  16  returned word
- vram_data_valid  in  1  vram_read_data is valid; arrives in order, at least 1 cycle after the ack
- meta_address  out  8  sprite index
- meta_write_data  out  16  attribute word
- meta_block_select  out  3  one-hot block select: 001 = x, 010 = y, 100 = g
- meta_we  out  1  metadata write strobe

Behaviour:
- Reset values: all outputs are 0 (busy, done, request, address, meta_*). Internal counters are 0 and the state is IDLE. Assertion takes effect immediately, mid-transfer included. An outstanding read's data is dropped after reset.
- Source layout is interleaved, 3 words per sprite: base+3i = x, base+3i+1 = y, base+3i+2 = g. Word order is x, y, g, then sprite i+1.
- The address counter is 14 bits and wraps modulo 16384 with no error.
- Count rule: effective count = min(sprite_count, MAX_SPRITES). A value of 0 on accepted start gives a single-cycle done pulse in the cycle after start, with busy never asserted and no VRAM requests.
- States are IDLE, REQUEST, WAIT_DATA and FLUSH.
- IDLE:
  - start with a nonzero count latches base/count, sets busy, and goes to REQUEST.
  - vram_data_valid is ignored.
- REQUEST:
  - vram_read_request = 1 with the current address.
  - On vram_read_ack, increment the address and go to WAIT_DATA. The request drops in the next cycle.
  - Only one read is outstanding at a time.
- WAIT_DATA:
  - When vram_data_valid arrives in cycle t, the write happens in cycle t+1:
    - meta_we = 1
    - meta_write_data = registered data
    - meta_address = sprite index
    - meta_block_select = one-hot of the current field
  - If words remain, vram_read_request is also high in t+1, so the minimum rate is 2 cycles per word with zero-latency ack and data.
  - The field advances x→y→g→x. After g, the sprite index increments; the index is 8 bits and reaches 255 at most.
  - After the final g word, done = 1 and busy = 0 in t+1, together with the final meta_we, and the state returns to IDLE.
- abort:
  - In REQUEST before ack, or in the same cycle as ack=0: drop the request and go to IDLE. busy falls next cycle; no done.
  - Once acked (WAIT_DATA, or REQUEST with ack in the same cycle): go to FLUSH, wait for the pending vram_data_valid, discard the data without writing, then go to IDLE. busy stays high through FLUSH and done is not pulsed.
  - Ignored in IDLE.
  - Simultaneous with the final valid: the final write is suppressed and done is not pulsed.
- start while busy is ignored; the running transfer is unaffected.
- start and abort in the same IDLE cycle: abort wins and the start is ignored.
- meta_we is never asserted outside the cycle after a valid in WAIT_DATA.
- done is 0 in all cycles except the completion pulse.

Test Plan:
- Single sprite: base = 0x0100, count = 1, ack same cycle, data 1 cycle later returning 0x0123, 0x0456, 0x0789 → three meta_we pulses with (addr 0, sel 001, 0x0123), (0, 010, 0x0456), (0, 100, 0x0789). Reads hit 0x0100–0x0102. done is coincident with the third write; busy lasts 6 cycles.
- Wrap and count: base = 0x3FFE, count = 2 → read addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001, 0x0002, 0x0003. Sprite 1's words land at meta_address 1.
- Back-pressure: ack held low for 5 cycles per request → request and address stay stable throughout, no duplicate reads, and the write order and values are unchanged.
- Clamp and zero: count = 300 → exactly 768 writes, last at meta_address 255, sel 100. count = 0 → done the cycle after start, no request, busy stays 0.
- Abort and restart: abort while WAIT_DATA is in progress on sprite 3's y word → that data is discarded (no meta_we), no done, busy falls after the valid. A start issued while busy earlier is ignored. A new start afterwards completes normally.
- Reset mid-transfer: deassert reset_n during the write cycle of sprite 5 → all outputs go to 0 asynchronously. After release, a stray vram_data_valid causes no meta_we.

Source files
------------

// File: rtl/vdp_sprite_meta_dma.sv
// Vblank copy engine: streams interleaved x/y/g sprite attribute words from VRAM
// into the sprite core's metadata blocks, one outstanding VRAM read at a time.
module vdp_sprite_meta_dma #(
   parameter int MAX_SPRITES = 256
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic        abort,
   input  logic [13:0] base_address,
   input  logic [8:0]  sprite_count,
   output logic        busy,
   output logic        done,
   output logic        vram_read_request,
   output logic [13:0] vram_read_address,
   input  logic        vram_read_ack,
   input  logic [15:0] vram_read_data,
   input  logic        vram_data_valid,
   output logic [7:0]  meta_address,
   output logic [15:0] meta_write_data,
   output logic [2:0]  meta_block_select,
   output logic        meta_we
);

   localparam int CW = $clog2(3 * MAX_SPRITES + 1);

   typedef enum logic [1:0] {IDLE, REQUEST, WAIT_DATA, FLUSH} state_t;

   state_t          state;
   logic [13:0]     addr;
   logic [CW-1:0]   words_left;
   logic [7:0]      idx;
   logic [1:0]      field;
   logic [8:0]      eff;
   logic [CW-1:0]   eff_words;

   assign eff       = (sprite_count > 9'(MAX_SPRITES)) ? 9'(MAX_SPRITES) : sprite_count;
   assign eff_words = CW'(eff) * CW'(3);

   // The request address is the live counter; it only moves on ack, so it is
   // stable for as long as the request is pending.
   assign vram_read_address = addr;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state             <= IDLE;
         addr              <= '0;
         words_left        <= '0;
         idx               <= '0;
         field             <= '0;
         busy              <= 1'b0;
         done              <= 1'b0;
         vram_read_request <= 1'b0;
         meta_address      <= '0;
         meta_write_data   <= '0;
         meta_block_select <= '0;
         meta_we           <= 1'b0;
      end else begin
         meta_we <= 1'b0;
         done    <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !abort) begin
                  if (eff == 9'd0) begin
                     done <= 1'b1;
                  end else begin
                     addr              <= base_address;
                     words_left        <= eff_words;
                     idx               <= '0;
                     field             <= '0;
                     busy              <= 1'b1;
                     vram_read_request <= 1'b1;
                     state             <= REQUEST;
                  end
               end
            end
            REQUEST: begin
               if (vram_read_ack) begin
                  addr              <= addr + 14'd1;
                  vram_read_request <= 1'b0;
                  state             <= abort ? FLUSH : WAIT_DATA;
               end else if (abort) begin
                  vram_read_request <= 1'b0;
                  busy              <= 1'b0;
                  state             <= IDLE;
               end
            end
            WAIT_DATA: begin
               if (vram_data_valid) begin
                  if (abort) begin
                     // data already arrived, so nothing is left to flush
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     meta_we           <= 1'b1;
                     meta_write_data   <= vram_read_data;
                     meta_address      <= idx;
                     meta_block_select <= 3'b001 << field;
                     words_left        <= words_left - CW'(1);
                     if (field == 2'd2) begin
                        field <= 2'd0;
                        idx   <= idx + 8'd1;
                     end else begin
                        field <= field + 2'd1;
                     end
                     if (words_left == CW'(1)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                     end else begin
                        vram_read_request <= 1'b1;
                        state             <= REQUEST;
                     end
                  end
               end else if (abort) begin
                  state <= FLUSH;
               end
            end
            FLUSH: begin
               if (vram_data_valid) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vdp_sprite_meta_dma.sv
// Directed bench for vdp_sprite_meta_dma: a VRAM responder with programmable
// ack/data latency and a scoreboard of expected reads and metadata writes.
module tb_vdp_sprite_meta_dma;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [13:0] base_address = '0;
   logic [8:0]  sprite_count = '0;
   logic        busy, done, vram_read_request, meta_we;
   logic [13:0] vram_read_address;
   logic        vram_read_ack = 1'b0;
   logic [15:0] vram_read_data = '0;
   logic        vram_data_valid = 1'b0;
   logic [7:0]  meta_address;
   logic [15:0] meta_write_data;
   logic [2:0]  meta_block_select;

   always #5 clk = ~clk;

   vdp_sprite_meta_dma #(.MAX_SPRITES(256)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .base_address(base_address), .sprite_count(sprite_count),
      .busy(busy), .done(done),
      .vram_read_request(vram_read_request), .vram_read_address(vram_read_address),
      .vram_read_ack(vram_read_ack), .vram_read_data(vram_read_data),
      .vram_data_valid(vram_data_valid),
      .meta_address(meta_address), .meta_write_data(meta_write_data),
      .meta_block_select(meta_block_select), .meta_we(meta_we)
   );

   typedef struct {
      logic [7:0]  a;
      logic [2:0]  s;
      logic [15:0] d;
      logic        last;
   } wexp_t;

   wexp_t       wq[$];
   logic [13:0] rq[$];
   logic [15:0] mem [0:16383];
   wexp_t       e_w;

   int checks = 0, fails = 0;
   int ack_delay = 0, data_lat = 1, pend = 0, req_wait = 0;
   int writes_seen = 0, acks_done = 0, done_cnt = 0, done_solo = 0, busy_cnt = 0;
   logic [15:0] pend_data = '0;
   logic        inj_valid = 1'b0;
   logic        prev_req = 1'b0, prev_ack = 1'b0;
   logic [13:0] prev_addr = '0;
   logic [7:0]  last_a = '0;
   logic [2:0]  last_s = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitor and VRAM responder share one negedge process so their order is fixed.
   initial forever begin
      @(negedge clk);
      if (!reset_n) begin
         pend = 0; req_wait = 0; prev_req = 1'b0; prev_ack = 1'b0;
         vram_read_ack = 1'b0; vram_data_valid = 1'b0;
      end else begin
         if (meta_we) begin
            writes_seen++;
            if (wq.size() == 0) chk("unexpected_we", 32'd1, 32'd0);
            else begin
               e_w = wq.pop_front();
               chk("we_addr", 32'(meta_address), 32'(e_w.a));
               chk("we_sel", 32'(meta_block_select), 32'(e_w.s));
               chk("we_data", 32'(meta_write_data), 32'(e_w.d));
               chk("we_done", 32'(done), 32'(e_w.last));
            end
            last_a = meta_address;
            last_s = meta_block_select;
         end
         if (done) done_cnt++;
         if (done && !meta_we) done_solo++;
         if (busy) busy_cnt++;
         if (vram_read_request && prev_req && !prev_ack)
            chk("req_addr_stable", 32'(vram_read_address), 32'(prev_addr));
         prev_req  = vram_read_request;
         prev_addr = vram_read_address;

         vram_data_valid = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               vram_data_valid = 1'b1;
               vram_read_data  = pend_data;
            end
         end
         if (inj_valid) begin
            vram_data_valid = 1'b1;
            vram_read_data  = 16'hDEAD;
         end
         vram_read_ack = 1'b0;
         if (vram_read_request) begin
            if (req_wait >= ack_delay) begin
               vram_read_ack = 1'b1;
               acks_done++;
               req_wait = 0;
               if (rq.size() == 0) chk("unexpected_read", 32'd1, 32'd0);
               else chk("read_addr", 32'(vram_read_address), 32'(rq.pop_front()));
               pend      = data_lat;
               pend_data = mem[vram_read_address];
            end else begin
               req_wait++;
            end
         end else begin
            req_wait = 0;
         end
         prev_ack = vram_read_ack;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [13:0] b, input logic [8:0] c);
      base_address = b;
      sprite_count = c;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic push_exp(input logic [13:0] base, input int nreads, input int nwrites, input int total);
      for (int k = 0; k < nreads; k++) rq.push_back(14'(base + 14'(k)));
      for (int k = 0; k < nwrites; k++) begin
         wexp_t e;
         e.a    = 8'(k / 3);
         e.s    = 3'(1 << (k % 3));
         e.d    = mem[14'(base + 14'(k))];
         e.last = (k == total - 1);
         wq.push_back(e);
      end
   endtask

   task automatic wait_idle(input string tag, input int limit);
      int i = 0;
      while ((busy || wq.size() != 0 || pend != 0) && i < limit) begin
         step();
         i++;
      end
      chk({tag, "_timeout"}, 32'(i < limit), 32'd1);
      chk({tag, "_writes_left"}, 32'(wq.size()), 32'd0);
      chk({tag, "_reads_left"}, 32'(rq.size()), 32'd0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, 32'({busy, done, vram_read_request, vram_read_address}), 32'd0);
      chk({tag, "_meta"}, 32'({meta_address, meta_write_data, meta_block_select, meta_we}), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int dc, ac, wc, i;
      for (int j = 0; j < 16384; j++) mem[j] = 16'(j * 37) ^ 16'h5A5A;
      mem[14'h0100] = 16'h0123;
      mem[14'h0101] = 16'h0456;
      mem[14'h0102] = 16'h0789;

      repeat (3) step();
      chk_zero("reset");
      reset_n = 1'b1;
      step();

      // single sprite, busy length and done coincident with the g write
      push_exp(14'h0100, 3, 3, 3);
      busy_cnt = 0;
      dc = done_cnt;
      pulse_start(14'h0100, 9'd1);
      wait_idle("single", 100);
      chk("single_busy_cycles", 32'(busy_cnt), 32'd6);
      chk("single_done", 32'(done_cnt - dc), 32'd1);

      // address wrap
      push_exp(14'h3FFE, 6, 6, 6);
      pulse_start(14'h3FFE, 9'd2);
      wait_idle("wrap", 100);
      chk("wrap_last_addr", 32'(last_a), 32'd1);

      // back-pressure
      ack_delay = 5;
      ac = acks_done;
      push_exp(14'h0200, 6, 6, 6);
      pulse_start(14'h0200, 9'd2);
      wait_idle("bp", 300);
      chk("bp_read_count", 32'(acks_done - ac), 32'd6);
      ack_delay = 0;

      // clamp
      wc = writes_seen;
      push_exp(14'h0400, 768, 768, 768);
      pulse_start(14'h0400, 9'd300);
      wait_idle("clamp", 4000);
      chk("clamp_writes", 32'(writes_seen - wc), 32'd768);
      chk("clamp_last_addr", 32'(last_a), 32'd255);
      chk("clamp_last_sel", 32'(last_s), 32'd4);

      // zero count
      ac = acks_done;
      pulse_start(14'h0500, 9'd0);
      chk("zero_done", 32'(done), 32'd1);
      chk("zero_busy", 32'(busy), 32'd0);
      chk("zero_req", 32'(vram_read_request), 32'd0);
      step();
      chk("zero_done_drop", 32'(done), 32'd0);
      chk("zero_no_reads", 32'(acks_done - ac), 32'd0);
      chk("zero_done_solo", 32'(done_solo), 32'd1);

      // start and abort together in IDLE
      abort = 1'b1;
      pulse_start(14'h0500, 9'd1);
      abort = 1'b0;
      chk("start_abort_busy", 32'(busy), 32'd0);
      chk("start_abort_req", 32'(vram_read_request), 32'd0);
      step();
      chk("start_abort_reads", 32'(acks_done - ac), 32'd0);

      // abort on sprite 3's y word, with an ignored start while busy
      data_lat = 4;
      ac = acks_done;
      dc = done_cnt;
      wc = writes_seen;
      push_exp(14'h0600, 11, 10, 12);
      pulse_start(14'h0600, 9'd4);
      repeat (3) step();
      pulse_start(14'h3000, 9'd5);
      i = 0;
      while (acks_done - ac < 11 && i < 500) begin
         step();
         i++;
      end
      chk("abort_wait_timeout", 32'(i < 500), 32'd1);
      step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_flush_busy", 32'(busy), 32'd1);
      wait_idle("abort", 100);
      repeat (3) step();
      chk("abort_no_done", 32'(done_cnt - dc), 32'd0);
      chk("abort_writes", 32'(writes_seen - wc), 32'd10);
      chk("abort_busy_low", 32'(busy), 32'd0);
      data_lat = 1;

      // restart after abort
      dc = done_cnt;
      push_exp(14'h0700, 6, 6, 6);
      pulse_start(14'h0700, 9'd2);
      wait_idle("restart", 100);
      chk("restart_done", 32'(done_cnt - dc), 32'd1);

      // reset during the first write of sprite 5
      wc = writes_seen;
      push_exp(14'h0800, 24, 24, 24);
      pulse_start(14'h0800, 9'd8);
      i = 0;
      while (writes_seen - wc < 16 && i < 500) begin
         step();
         i++;
      end
      chk("rst_wait_timeout", 32'(i < 500), 32'd1);
      chk("rst_in_write", 32'({meta_we, meta_address}), 32'h105);
      #1 reset_n = 1'b0;
      #1 chk_zero("rst_async");
      wq.delete();
      rq.delete();
      repeat (2) step();
      reset_n = 1'b1;
      step();
      wc = writes_seen;
      inj_valid = 1'b1;
      step();
      inj_valid = 1'b0;
      repeat (4) step();
      chk("stray_valid_no_we", 32'(writes_seen - wc), 32'd0);
      chk("stray_valid_busy", 32'(busy), 32'd0);
      chk("final_done_solo", 32'(done_solo), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
